// File: rtl/audio_voice_sched.sv
// Voice scheduler for the 7-voice audio block: takes note commands, drives the counter-load
// handshake, times note durations and time-slices the shared 1-bit output across active voices.
module audio_voice_sched #(
    parameter int TICK_DIV    = 50000,
    parameter int SLOT_CYCLES = 256,
    parameter int DUR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_voice,
    input  logic [5:0]       cmd_note,
    input  logic [DUR_W-1:0] cmd_dur,
    output logic [2:0]       counter_load_num,
    output logic [5:0]       freq_addr,
    output logic             dout_en,
    output logic [2:0]       dout_sel,
    output logic [6:0]       voice_active
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  load_num_q, load_num_d;
    logic [5:0]                  freq_addr_q, freq_addr_d;
    logic                        dout_en_q, dout_en_d;
    logic [2:0]                  dout_sel_q, dout_sel_d;
    logic [6:0]                  active_q, active_d;
    logic [6:0][DUR_W-1:0]       rem_q, rem_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic [SW-1:0]               slot_q, slot_d;

    logic       tick, accept, found;
    logic [3:0] idx;
    logic [2:0] nxt;

    always_comb begin
        state_d     = state_q;
        load_num_d  = load_num_q;
        freq_addr_d = freq_addr_q;
        active_d    = active_q;
        rem_d       = rem_q;
        slot_d      = slot_q;
        dout_sel_d  = dout_sel_q;
        dout_en_d   = |active_q;
        tick        = (presc_q == PRESC_MAX);
        presc_d     = tick ? '0 : presc_q + 1'b1;
        accept      = cmd_valid && (state_q == IDLE);

        unique case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: begin
                state_d    = HOLD;
                load_num_d = 3'b111;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A command to a voice overrides that voice's tick decrement on the same edge.
        for (int v = 0; v < 7; v++) begin
            if (tick && rem_q[v] != '0) begin
                rem_d[v] = rem_q[v] - 1'b1;
                if (rem_q[v] == DUR_W'(1)) active_d[v] = 1'b0;
            end
            if (accept && cmd_voice == 3'(v)) begin
                rem_d[v]    = cmd_dur;
                active_d[v] = (cmd_dur != '0);
                if (cmd_dur != '0) begin
                    load_num_d  = cmd_voice;
                    freq_addr_d = cmd_note;
                end
            end
        end

        // Next active voice after the current one, wrapping 6->0; offset 7 is the current voice.
        nxt   = dout_sel_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= 7; k++) begin
            idx = 4'(dout_sel_q) + 4'(k);
            if (idx >= 4'd7) idx = idx - 4'd7;
            if (!found && active_q[idx[2:0]]) begin
                nxt   = idx[2:0];
                found = 1'b1;
            end
        end

        if (!(|active_q)) begin
            slot_d = '0;
        end else if (!active_q[dout_sel_q] || slot_q == SLOT_MAX) begin
            slot_d     = '0;
            dout_sel_d = nxt;
        end else begin
            slot_d = slot_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_num_q  <= 3'b111;
            freq_addr_q <= '0;
            dout_en_q   <= 1'b0;
            dout_sel_q  <= '0;
            active_q    <= '0;
            rem_q       <= '0;
            presc_q     <= '0;
            slot_q      <= '0;
        end else begin
            state_q     <= state_d;
            load_num_q  <= load_num_d;
            freq_addr_q <= freq_addr_d;
            dout_en_q   <= dout_en_d;
            dout_sel_q  <= dout_sel_d;
            active_q    <= active_d;
            rem_q       <= rem_d;
            presc_q     <= presc_d;
            slot_q      <= slot_d;
        end
    end

    assign cmd_ready        = (state_q == IDLE);
    assign counter_load_num = load_num_q;
    assign freq_addr        = freq_addr_q;
    assign dout_en          = dout_en_q;
    assign dout_sel         = dout_sel_q;
    assign voice_active     = active_q;
endmodule
